// File: rtl/opb_pkg.sv
// Shared OPB slave definitions: state encoding, register classes,
// byte-lane mapping and address-window compare.
package opb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } opb_state_t;

  typedef enum logic [1:0] {
    K_CTRL,
    K_STAT,
    K_BAD
  } reg_kind_t;

  // OPB lane k (big-endian) maps to register bits [lsb+7:lsb]
  function automatic int lane_lsb(input int k);
    return 24 - 8 * k;
  endfunction

  function automatic logic in_window(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/opb_be_reg32.sv
// 32-bit register with per-byte write enables in OPB lane order.
// Async active-low reset to a parameterised value.
module opb_be_reg32 #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [0:3]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);
  import opb_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) q[lane_lsb(k) +: 8] <= d[lane_lsb(k) +: 8];
      end
    end
  end

endmodule

// File: rtl/opb_sw_reg_slave.sv
// OPB slave exposing software control (r/w) and status (r/o) registers
// with a programmable wait-state count before each acknowledge.
module opb_sw_reg_slave #(
  parameter logic [31:0] C_BASEADDR    = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100_00FF,
  parameter int          C_NUM_CTRL    = 4,
  parameter int          C_NUM_STAT    = 4,
  parameter int          C_WAIT_STATES = 1,
  parameter logic [31:0] C_CTRL_RST    = 32'h0000_0000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_CTRL*32-1:0] user_ctrl,
  output logic [C_NUM_CTRL-1:0]   user_ctrl_wr,
  input  logic [(C_NUM_STAT > 0 ? C_NUM_STAT : 1)*32-1:0] user_stat
);
  import opb_pkg::*;

  opb_state_t state, state_nx;
  logic [3:0] cnt;

  logic [31:0] addr, off, word;
  logic        hit;
  reg_kind_t   kind;
  logic [31:0] stat_sel;

  logic [31:0] idx_q;
  logic        rnw_q;
  logic [0:3]  be_q;
  logic [31:0] dat_q;
  reg_kind_t   kind_q;
  logic [31:0] stat_q;

  logic [31:0] ctrl_sel, rdata;
  logic        ack, err, commit;
  logic [C_NUM_CTRL-1:0] wr_en;
  logic        unused_ok;

  assign addr = OPB_ABus;
  assign off  = addr - C_BASEADDR;
  assign word = {2'b00, off[31:2]};
  assign hit  = OPB_select && in_window(addr, C_BASEADDR, C_HIGHADDR);

  assign unused_ok = ^{OPB_seqAddr, off[1:0]};

  always_comb begin
    kind = K_BAD;
    if (word < 32'(C_NUM_CTRL)) kind = K_CTRL;
    else if (word < 32'(C_NUM_CTRL + C_NUM_STAT)) kind = K_STAT;
  end

  always_comb begin
    stat_sel = '0;
    for (int i = 0; i < C_NUM_STAT; i++) begin
      if (word == 32'(C_NUM_CTRL + i)) stat_sel = user_stat[i*32 +: 32];
    end
  end

  // Status is shadowed at decode so it stays stable through the wait states
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      rnw_q  <= 1'b0;
      be_q   <= '0;
      dat_q  <= '0;
      kind_q <= K_BAD;
      stat_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && hit) begin
        cnt    <= 4'(C_WAIT_STATES);
        idx_q  <= word;
        rnw_q  <= OPB_RNW;
        be_q   <= OPB_BE;
        dat_q  <= OPB_DBus;
        kind_q <= kind;
        stat_q <= stat_sel;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (hit) state_nx = (C_WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!OPB_select) state_nx = S_IDLE;
        else if (cnt == 4'd1) state_nx = S_ACK;
      end
      S_ACK:   state_nx = S_HOLD;
      S_HOLD:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_sel = '0;
    for (int i = 0; i < C_NUM_CTRL; i++) begin
      if (idx_q == 32'(i)) ctrl_sel = user_ctrl[i*32 +: 32];
    end
  end

  assign ack    = (state == S_ACK);
  assign err    = ack && (kind_q == K_BAD ||
                          (kind_q == K_STAT && !rnw_q));
  assign commit = ack && !rnw_q && (kind_q == K_CTRL);
  assign rdata  = (kind_q == K_CTRL) ? ctrl_sel : stat_q;

  assign Sl_xferAck = ack;
  assign Sl_errAck  = err;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = (state == S_WAIT);
  assign Sl_DBus    = (ack && rnw_q && !err) ? rdata : '0;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) user_ctrl_wr <= '0;
    else            user_ctrl_wr <= wr_en;
  end

  for (genvar i = 0; i < C_NUM_CTRL; i++) begin : g_ctrl
    assign wr_en[i] = commit && (idx_q == 32'(i));
    opb_be_reg32 #(
      .RST_VAL(C_CTRL_RST)
    ) u_reg (
      .clk  (OPB_Clk),
      .rst_n(OPB_Rst_n),
      .en   (wr_en[i]),
      .be   (be_q),
      .d    (dat_q),
      .q    (user_ctrl[i*32 +: 32])
    );
  end

endmodule
